sram_rw_arbiter: RTL

Single-port SRAM access controller that shares one 512x64 macro between a write requester and a read requester. Per cycle it grants at most one access, drives the macro's active-low controls (CEB, WEB, BWEB), and returns read data through a 2-entry response buffer with backpressure. It sits between the memory-core tile logic and the SRAM macro instance; the macro itself is instantiated outside this block.

---
 rtl/sram_arb_pkg.sv | 19 +
 rtl/sram_rsp_fifo.sv | 66 ++++++
 rtl/sram_rw_arbiter.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types and helpers for the SRAM read/write arbiter.
//   grant_t      : which requester owns the macro this cycle
//   RSP_DEPTH    : read response buffer entries
//   byte_to_bweb : expands one active-high byte enable into eight active-low mask bits
package sram_arb_pkg;

    localparam int unsigned RSP_DEPTH = 2;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_WR   = 2'd1,
        GNT_RD   = 2'd2
    } grant_t;

    function automatic logic [7:0] byte_to_bweb(input logic be);
        return {8{~be}};
    endfunction

endpackage

// File: rtl/sram_rsp_fifo.sv
// Small synchronous FIFO holding read data that the consumer has not yet taken.
//   clk, reset         : clock, synchronous active-high reset (clears pointers/count)
//   push, push_data    : write an entry
//   pop                : drop the head entry
//   head               : current head data (undefined when empty)
//   full, empty, count : occupancy status
module sram_rsp_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    // Storage needs no reset: entries are only read once counted as valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= ptr_next(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_next(rd_ptr_q);
            end
            if (push && !pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    assign head  = mem[rd_ptr_q];
    assign count = count_q;
    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/sram_rw_arbiter.sv
// Single-port SRAM access controller shared by one write and one read requester.
// Grants at most one access per cycle (round-robin on ties), drives the macro's active-low
// controls, and returns read data in order through a small response buffer with backpressure.
//   CLK, RESET                         : clock, synchronous active-high reset
//   wr_valid/wr_ready/wr_addr/wr_data/wr_be : write request channel
//   rd_valid/rd_ready/rd_addr          : read request channel
//   rsp_valid/rsp_ready/rsp_data       : read response channel
//   sram_ceb/web/a/d/bweb              : macro controls (active low enables/mask)
//   sram_q                             : macro read data, valid the cycle after a read edge
module sram_rw_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned WIDTH      = 64,
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned RSP_DEPTH  = sram_arb_pkg::RSP_DEPTH
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic [WIDTH/8-1:0]    wr_be,
    input  logic                  rd_valid,
    output logic                  rd_ready,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WIDTH-1:0]      rsp_data,
    output logic                  sram_ceb,
    output logic                  sram_web,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic [WIDTH-1:0]      sram_d,
    output logic [WIDTH-1:0]      sram_bweb,
    input  logic [WIDTH-1:0]      sram_q
);

    localparam int unsigned BE_W  = WIDTH / 8;
    localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int unsigned PW    = CNT_W + 1;

    // armed_q keeps every grant off during reset and the first cycle after it.
    logic   armed_q;
    logic   inflight_q;
    logic   last_rd_q;      // 1: read was granted last, so write wins the next tie
    grant_t grant;

    logic   active;
    logic   wr_elig;
    logic   rd_elig;
    logic   rsp_take;

    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_head;
    logic [CNT_W-1:0] fifo_count;

    logic [PW-1:0]    pending;
    logic [PW-1:0]    allowed;
    logic [WIDTH-1:0] wr_bweb;

    assign active = armed_q & ~RESET;

    // Response side: buffer head has priority; an empty buffer bypasses sram_q directly.
    assign rsp_valid = ~RESET & (~fifo_empty | inflight_q);
    assign rsp_take  = rsp_valid & rsp_ready;
    assign fifo_pop  = rsp_take & ~fifo_empty;
    // Park the arriving word unless it was consumed through the bypass.
    assign fifo_push = inflight_q & ~(fifo_empty & rsp_ready);

    always_comb begin
        rsp_data = '0;
        if (rsp_valid) begin
            rsp_data = fifo_empty ? sram_q : fifo_head;
        end
    end

    // Credits: a response consumed this cycle frees its slot immediately.
    assign pending = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_q};
    assign allowed = PW'(RSP_DEPTH) + {{CNT_W{1'b0}}, rsp_take};

    assign wr_elig = active & wr_valid;
    assign rd_elig = active & rd_valid & (pending < allowed);

    always_comb begin
        grant = GNT_NONE;
        if (wr_elig && rd_elig) begin
            grant = last_rd_q ? GNT_WR : GNT_RD;
        end else if (wr_elig) begin
            grant = GNT_WR;
        end else if (rd_elig) begin
            grant = GNT_RD;
        end
    end

    assign wr_ready = (grant == GNT_WR);
    assign rd_ready = (grant == GNT_RD);

    always_comb begin
        wr_bweb = '1;
        for (int unsigned i = 0; i < BE_W; i++) begin
            wr_bweb[i*8 +: 8] = byte_to_bweb(wr_be[i]);
        end
    end

    always_comb begin
        sram_ceb  = 1'b1;
        sram_web  = 1'b1;
        sram_a    = '0;
        sram_d    = '0;
        sram_bweb = '1;
        unique case (grant)
            GNT_WR: begin
                sram_ceb  = 1'b0;
                sram_web  = 1'b0;
                sram_a    = wr_addr;
                sram_d    = wr_data;
                sram_bweb = wr_bweb;
            end
            GNT_RD: begin
                sram_ceb = 1'b0;
                sram_a   = rd_addr;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            armed_q    <= 1'b0;
            inflight_q <= 1'b0;
            last_rd_q  <= 1'b1;
        end else begin
            armed_q    <= 1'b1;
            inflight_q <= (grant == GNT_RD);
            if (grant != GNT_NONE) begin
                last_rd_q <= (grant == GNT_RD);
            end
        end
    end

    sram_rsp_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk       (CLK),
        .reset     (RESET),
        .push      (fifo_push),
        .push_data (sram_q),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Credits must keep the buffer from ever overflowing.
    assert property (@(posedge CLK) disable iff (RESET) !(fifo_push && fifo_full && !fifo_pop));

endmodule
